// File: rtl/rob_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
package rob_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int REG_W_DEF  = 5;

    // Control part of an entry; dest/data widths follow the instance parameters and are stored alongside.
    typedef struct packed {
        logic valid;
        logic done;
        logic mispredict;
        logic is_branch;
        logic reg_write;
    } rob_entry_t;

    function automatic int clog2_depth(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/rob_wb_merge.sv
// Per-entry writeback selector: finds the lowest-index channel whose tag equals IDX.
// Purely combinational; no backpressure.
module rob_wb_merge #(
    parameter int WB_PORTS = 2,
    parameter int TAG_W    = 3,
    parameter int DATA_W   = 64,
    parameter int IDX      = 0
) (
    input  logic [WB_PORTS-1:0]        i_wb_vld,
    input  logic [WB_PORTS*TAG_W-1:0]  i_wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0] i_wb_dat,
    input  logic [WB_PORTS-1:0]        i_wb_mis,
    output logic                       o_hit,
    output logic [DATA_W-1:0]          o_dat,
    output logic                       o_mis
);
    always_comb begin
        o_hit = 1'b0;
        o_dat = '0;
        o_mis = 1'b0;
        // Scan from the top so the lowest matching channel is the last writer.
        for (int i = WB_PORTS - 1; i >= 0; i--) begin
            if (i_wb_vld[i] && (i_wb_tag[i*TAG_W +: TAG_W] == TAG_W'(IDX))) begin
                o_hit = 1'b1;
                o_dat = i_wb_dat[i*DATA_W +: DATA_W];
                o_mis = i_wb_mis[i];
            end
        end
    end
endmodule

// File: rtl/rob_param.sv
// Reorder buffer: in-order allocate/commit, multi-channel writeback, flush on mispredicted-branch commit.
// Optional perf counters under ROB_PERF_CNT_EN. Commit is combinational from head; writeback->commit >= 1 cycle.
module rob_param
    import rob_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_W    = REG_W_DEF,
    localparam int TAG_W   = clog2_depth(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [REG_W-1:0]           alloc_dest,
    input  logic                       alloc_regWrite,
    input  logic                       alloc_isBranch,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]  wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0] wb_data,
    input  logic [WB_PORTS-1:0]        wb_mispredict,
    input  logic [TAG_W-1:0]           rd_tag,
    output logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       commit_valid,
    input  logic                       commit_ready,
    output logic [REG_W-1:0]           commit_dest,
    output logic                       commit_regWrite,
    output logic [DATA_W-1:0]          commit_data,
    output logic                       flush_o,
    output logic [TAG_W:0]             count
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]                perf_commits,
    output logic [31:0]                perf_flushes
`endif
);
    localparam int CNT_W = TAG_W + 1;

    rob_entry_t        r_ent  [DEPTH];
    logic [REG_W-1:0]  r_dest [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_flush;

    logic [DEPTH-1:0]  w_hit;
    logic [DEPTH-1:0]  w_mis;
    logic [DEPTH-1:0]  w_wb_we;
    logic [DATA_W-1:0] w_wdat [DEPTH];
    logic              w_alloc_fire;
    logic              w_commit_fire;
    logic              w_flush_fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_merge
        rob_wb_merge #(
            .WB_PORTS(WB_PORTS),
            .TAG_W   (TAG_W),
            .DATA_W  (DATA_W),
            .IDX     (g)
        ) u_merge (
            .i_wb_vld(wb_valid),
            .i_wb_tag(wb_tag),
            .i_wb_dat(wb_data),
            .i_wb_mis(wb_mispredict),
            .o_hit   (w_hit[g]),
            .o_dat   (w_wdat[g]),
            .o_mis   (w_mis[g])
        );
        // Writebacks only land on entries already allocated; flush-cycle results are dropped.
        assign w_wb_we[g] = w_hit[g] && r_ent[g].valid && !r_flush;
    end

    assign alloc_ready     = (r_count != CNT_W'(DEPTH)) && !r_flush;
    assign alloc_tag       = r_tail;
    assign commit_valid    = r_ent[r_head].valid && r_ent[r_head].done;
    assign commit_dest     = commit_valid ? r_dest[r_head] : '0;
    assign commit_regWrite = commit_valid && r_ent[r_head].reg_write;
    assign commit_data     = commit_valid ? r_data[r_head] : '0;
    assign rd_ready        = r_ent[rd_tag].valid && r_ent[rd_tag].done;
    assign rd_data         = rd_ready ? r_data[rd_tag] : '0;
    assign flush_o         = r_flush;
    assign count           = r_count;

    assign w_alloc_fire  = alloc_valid && alloc_ready;
    assign w_commit_fire = commit_valid && commit_ready;
    assign w_flush_fire  = w_commit_fire && r_ent[r_head].mispredict;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flush <= 1'b0;
            for (int e = 0; e < DEPTH; e++) r_ent[e] <= '0;
        end else if (w_flush_fire) begin
            // The branch itself retires; everything younger is wrong-path.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flush <= 1'b1;
            for (int e = 0; e < DEPTH; e++) begin
                r_ent[e].valid <= 1'b0;
                r_ent[e].done  <= 1'b0;
            end
        end else begin
            r_flush <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wb_we[e]) begin
                    r_ent[e].done       <= 1'b1;
                    r_ent[e].mispredict <= w_mis[e];
                end
            end
            if (w_commit_fire) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + TAG_W'(1);
            end
            if (w_alloc_fire) begin
                r_ent[r_tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                   is_branch: alloc_isBranch, reg_write: alloc_regWrite};
                r_tail        <= r_tail + TAG_W'(1);
            end
            case ({w_alloc_fire, w_commit_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload is qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_wb_we[e]) r_data[e] <= w_wdat[e];
        end
        if (w_alloc_fire) r_dest[r_tail] <= alloc_dest;
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_perf_commits;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_commits <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_commit_fire && (r_perf_commits != 32'hFFFF_FFFF))
                r_perf_commits <= r_perf_commits + 32'd1;
            if (w_flush_fire && (r_perf_flushes != 32'hFFFF_FFFF))
                r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_commits = r_perf_commits;
    assign perf_flushes = r_perf_flushes;
`endif
endmodule
